// File: rtl/regfile_pkg.sv
// regfile_pkg: default sizes and helpers shared by the register file blocks
package regfile_pkg;
  localparam int REGFILE_WIDTH = 64;
  localparam int REGFILE_DEPTH = 32;
  localparam int REGFILE_NREAD = 2;
  function automatic int zero_reg_idx(input int depth);
    return depth - 1;
  endfunction
endpackage

// File: rtl/regfile_word.sv
// regfile_word: one WIDTH-bit storage word with synchronous clear and load enable
module regfile_word
  import regfile_pkg::*;
#(
  parameter int WIDTH = REGFILE_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeEnable,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out
);
  always_ff @(posedge clk)
    if (reset) out <= '0;
    else if (writeEnable) out <= in;
endmodule

// File: rtl/regfile_param.sv
// regfile_param: parametrised multi-port register file with optional zero register;
// define REGFILE_BYPASS_EN to make a write visible to same-cycle reads
module regfile_param
  import regfile_pkg::*;
#(
  parameter int WIDTH    = REGFILE_WIDTH,
  parameter int DEPTH    = REGFILE_DEPTH,
  parameter int NREAD    = REGFILE_NREAD,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             writeEnable,
  input  logic [AW-1:0]    writeAddr,
  input  logic [WIDTH-1:0] writeData,
  input  logic [AW-1:0]    readAddr [NREAD],
  output logic [WIDTH-1:0] readData [NREAD]
);
  localparam int ZI = zero_reg_idx(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    if (ZERO_REG != 0 && e == ZI) begin : g_zero
      assign mem[e] = '0;
    end else begin : g_word
      regfile_word #(.WIDTH(WIDTH)) u_word (
        .clk(clk),
        .reset(reset),
        .writeEnable(writeEnable && writeAddr == AW'(e)),
        .in(writeData),
        .out(mem[e])
      );
    end
  end
`ifdef REGFILE_BYPASS_EN
  logic wr_ok;
  assign wr_ok = int'(writeAddr) < DEPTH && !(ZERO_REG != 0 && int'(writeAddr) == ZI);
`endif
  for (genvar p = 0; p < NREAD; p++) begin : g_rd
    logic hit;
`ifdef REGFILE_BYPASS_EN
    assign hit = writeEnable && !reset && readAddr[p] == writeAddr && wr_ok;
`else
    assign hit = 1'b0;
`endif
    // addresses past DEPTH only exist when DEPTH is not a power of two
    assign readData[p] = hit ? writeData : int'(readAddr[p]) < DEPTH ? mem[readAddr[p]] : '0;
  end
endmodule

// File: tb/tb_regfile_param.sv
// tb_regfile_param: scoreboard bench for a default regfile_param and a 32x16x3 no-zero-register variant
module tb_regfile_param;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  logic a_we;
  logic [4:0] a_wa;
  logic [63:0] a_wd;
  logic [4:0] a_ra [2];
  logic [63:0] a_rd [2];
  logic b_we;
  logic [3:0] b_wa;
  logic [31:0] b_wd;
  logic [3:0] b_ra [3];
  logic [31:0] b_rd [3];

  regfile_param dut_a (
    .clk(clk), .reset(rst), .writeEnable(a_we), .writeAddr(a_wa),
    .writeData(a_wd), .readAddr(a_ra), .readData(a_rd)
  );
  regfile_param #(.WIDTH(32), .DEPTH(16), .NREAD(3), .ZERO_REG(0)) dut_b (
    .clk(clk), .reset(rst), .writeEnable(b_we), .writeAddr(b_wa),
    .writeData(b_wd), .readAddr(b_ra), .readData(b_rd)
  );

  logic [63:0] ma [32];
  logic [31:0] mb [16];
  typedef struct {
    int s;
    logic [2:0][63:0] d;
  } exp_t;
  exp_t qa[$];
  exp_t qb[$];
  int tests = 0;
  int fails = 0;
  int nstep = 0;

  function automatic logic [63:0] exp_a(input logic [4:0] ra);
    if (ra == 5'd31) return 64'd0;
    if (BYP && a_we && !rst && ra == a_wa) return a_wd;
    return ma[ra];
  endfunction

  function automatic logic [31:0] exp_b(input logic [3:0] ra);
    if (BYP && b_we && !rst && ra == b_wa) return b_wd;
    return mb[ra];
  endfunction

  task automatic step(input logic r, input logic we, input logic [4:0] wa,
                      input logic [63:0] wd, input logic [4:0] r0, input logic [4:0] r1,
                      input bit chk);
    exp_t ea, eb;
    rst = r;
    a_we = we; a_wa = wa; a_wd = wd; a_ra[0] = r0; a_ra[1] = r1;
    b_we = 1'($urandom); b_wa = 4'($urandom); b_wd = $urandom;
    for (int i = 0; i < 3; i++) b_ra[i] = 4'($urandom);
    if (chk) begin
      ea.s = nstep; eb.s = nstep; ea.d = '0; eb.d = '0;
      for (int i = 0; i < 2; i++) ea.d[i] = exp_a(a_ra[i]);
      for (int i = 0; i < 3; i++) eb.d[i] = 64'(exp_b(b_ra[i]));
      qa.push_back(ea);
      qb.push_back(eb);
    end
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) ma[i] = '0;
      for (int i = 0; i < 16; i++) mb[i] = '0;
    end else begin
      if (we && wa != 5'd31) ma[wa] = wd;
      if (b_we) mb[b_wa] = b_wd;
    end
    #1;
    nstep++;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (qa.size() > 0) begin
      e = qa.pop_front();
      for (int p = 0; p < 2; p++) begin
        tests++;
        if (a_rd[p] !== e.d[p]) begin
          fails++;
          $display("FAIL a_port%0d step %0d: got %h want %h", p, e.s, a_rd[p], e.d[p]);
        end
      end
    end
    if (qb.size() > 0) begin
      e = qb.pop_front();
      for (int p = 0; p < 3; p++) begin
        tests++;
        if (b_rd[p] !== e.d[p][31:0]) begin
          fails++;
          $display("FAIL b_port%0d step %0d: got %h want %h", p, e.s, b_rd[p], e.d[p][31:0]);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 32; i++) ma[i] = '0;
    for (int i = 0; i < 16; i++) mb[i] = '0;
    rst = 1'b1; a_we = 1'b0; a_wa = '0; a_wd = '0; a_ra[0] = '0; a_ra[1] = '0;
    b_we = 1'b0; b_wa = '0; b_wd = '0;
    for (int i = 0; i < 3; i++) b_ra[i] = '0;
    @(posedge clk); #1;
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b0);
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd1, 1'b1);
    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, 5'd0, 64'd0, 5'(i), 5'(31 - i), 1'b1);
    // directed cases run after a fresh reset so dut_b noise does not matter to dut_a
    step(1'b1, 1'b0, 5'd0, 64'd0, 5'd0, 5'd0, 1'b1);
    step(1'b0, 1'b1, 5'd5, 64'hDEAD_BEEF_0000_0001, 5'd5, 5'd4, 1'b1);
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd5, 5'd4, 1'b1);
    step(1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF, 5'd31, 5'd31, 1'b1);
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd31, 5'd31, 1'b1);
    step(1'b0, 1'b1, 5'd7, 64'h55, 5'd6, 5'd6, 1'b1);
    step(1'b0, 1'b1, 5'd7, 64'h1234, 5'd7, 5'd6, 1'b1);
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd7, 5'd7, 1'b1);
    step(1'b0, 1'b1, 5'd3, 64'h77, 5'd3, 5'd3, 1'b1);
    step(1'b1, 1'b1, 5'd3, 64'hAA, 5'd3, 5'd7, 1'b1);
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd3, 5'd7, 1'b1);
    step(1'b1, 1'b1, 5'd9, 64'h99, 5'd9, 5'd9, 1'b1);
    step(1'b1, 1'b1, 5'd9, 64'h98, 5'd9, 5'd9, 1'b1);
    step(1'b0, 1'b1, 5'd9, 64'h1, 5'd9, 5'd9, 1'b1);
    step(1'b0, 1'b1, 5'd9, 64'h2, 5'd9, 5'd9, 1'b1);
    step(1'b0, 1'b0, 5'd0, 64'd0, 5'd9, 5'd9, 1'b1);
    for (int i = 0; i < 10000; i++)
      step($urandom_range(199) == 0, 1'($urandom), 5'($urandom), {$urandom, $urandom},
           5'($urandom), 5'($urandom), 1'b1);
    @(posedge clk);
    if (qa.size() != 0 || qb.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d/%0d entries left, want 0", qa.size(), qb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
